// File: rtl/nes_controller_reader.sv
// nes_controller_reader: polls an NES serial pad once per frame and presents registered active-high button levels
module nes_controller_reader #(
  parameter int HALF_PERIOD   = 150,
  parameter int LATCH_PERIODS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_rate,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic       button_a,
  output logic       button_b,
  output logic       button_select,
  output logic       button_start,
  output logic       button_up,
  output logic       button_down,
  output logic       button_left,
  output logic       button_right,
  output logic [7:0] buttons,
  output logic       read_valid,
  output logic       busy
);
  localparam int L  = LATCH_PERIODS * HALF_PERIOD;
  localparam int CW = $clog2(L + 1);
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, buttons_q, buttons_d;
  logic sync1_q, sync2_q;
  logic latch_q, latch_d, clk_q, clk_d, valid_q, valid_d, busy_q, busy_d;
  logic half_end;
  assign half_end = cnt_q == CW'(HALF_PERIOD - 1);
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    case (state_q)
      IDLE:  state_d = frame_rate ? LATCH : IDLE;
      LATCH: if (cnt_q == CW'(L - 1)) begin
        state_d = LOW;
        bit_d   = 3'd0;
      end
      LOW: if (half_end) begin
        shift_d[bit_q] = sync2_q;
        state_d        = (bit_q == 3'd7) ? DONE : HIGH;
        if (bit_q == 3'd7) buttons_d = ~{sync2_q, shift_q[6:0]};
      end
      HIGH: if (half_end) begin
        state_d = LOW;
        bit_d   = bit_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    cnt_d   = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    latch_d = state_d == LATCH;
    clk_d   = state_d == HIGH;
    valid_d = state_d == DONE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    sync1_q <= ctrl_data;
    sync2_q <= sync1_q;
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      clk_q     <= clk_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end
  assign ctrl_latch    = latch_q;
  assign ctrl_clk      = clk_q;
  assign read_valid    = valid_q;
  assign busy          = busy_q;
  assign buttons       = buttons_q;
  assign button_a      = buttons_q[0];
  assign button_b      = buttons_q[1];
  assign button_select = buttons_q[2];
  assign button_start  = buttons_q[3];
  assign button_up     = buttons_q[4];
  assign button_down   = buttons_q[5];
  assign button_left   = buttons_q[6];
  assign button_right  = buttons_q[7];
endmodule
